vram_blit_writer: RTL and testbench

//  Consumes the per-layer address stream from the layer sequencer and turns it into VRAM writes.
//  - Issues the sprite-buffer read address and realigns it with the BRAM read data.
//  - Drops transparent-key and off-screen pixels.
//  - Writes surviving pixels into the back bank of a double-buffered VRAM.
//  - Swaps front/back banks on screenend once the frame is fully written.

---
 rtl/vram_blit_writer.sv | 184 ++++++++++++++++++
 tb/tb_vram_blit_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vram_blit_writer.sv
`default_nettype none
// ============================================================================
// Module  : vram_blit_writer
// Brief   : Realigns sprite-buffer reads with target addresses, drops keyed or
//           off-screen pixels, writes the back VRAM bank and swaps banks.
// Revision: 1.0 - initial release
// ============================================================================
module vram_blit_writer #(
    parameter int               VRAM_A_WIDTH      = 16,
    parameter int               SPRITEBUF_A_WIDTH = 14,
    parameter int               COLOR_WIDTH       = 12,
    parameter int               SCREEN_WIDTH      = 320,
    parameter int               SCREEN_HEIGHT     = 180,
    parameter int               READ_LATENCY      = 1,
    parameter logic [11:0]      TRANSPARENT_KEY   = 12'hF0F
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         i_is_layer_drawing,
    input  logic [VRAM_A_WIDTH-1:0]      i_address_screen,
    input  logic [SPRITEBUF_A_WIDTH-1:0] i_address_s,
    input  logic                         i_screenend,
    output logic [SPRITEBUF_A_WIDTH-1:0] o_sprite_addr,
    input  logic [COLOR_WIDTH-1:0]       i_sprite_data,
    output logic                         o_vram_we,
    output logic [VRAM_A_WIDTH:0]        o_vram_addr,
    output logic [COLOR_WIDTH-1:0]       o_vram_din,
    output logic                         o_disp_bank,
    output logic                         o_frame_ready,
    output logic [15:0]                  o_pix_written,
    output logic                         o_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [VRAM_A_WIDTH:0]  SCREEN_PIXELS =
        (VRAM_A_WIDTH+1)'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [1:0]             FLUSH_LAST    = 2'(READ_LATENCY);
    localparam logic [COLOR_WIDTH-1:0] KEY           = COLOR_WIDTH'(TRANSPARENT_KEY);

    logic                    pipe_v_q [READ_LATENCY];
    logic                    pipe_v_d [READ_LATENCY];
    logic [VRAM_A_WIDTH-1:0] pipe_a_q [READ_LATENCY];
    logic [VRAM_A_WIDTH-1:0] pipe_a_d [READ_LATENCY];

    logic [1:0]              state_q, state_d;
    logic [1:0]              flush_cnt_q, flush_cnt_d;
    logic                    vram_we_q, vram_we_d;
    logic [VRAM_A_WIDTH:0]   vram_addr_q, vram_addr_d;
    logic [COLOR_WIDTH-1:0]  vram_din_q, vram_din_d;
    logic                    disp_bank_q, disp_bank_d;
    logic                    frame_ready_q, frame_ready_d;
    logic [15:0]             pix_written_q, pix_written_d;
    logic                    overrun_q, overrun_d;
    logic                    clear_cnt;

    assign o_sprite_addr = i_address_s;

    always_comb begin
        pipe_v_d[0] = i_is_layer_drawing;
        pipe_a_d[0] = i_address_screen;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_a_d[i] = pipe_a_q[i-1];
        end
    end

    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
        always_ff @(posedge CLK or negedge rst) begin
            if (!rst) begin
                pipe_v_q[g] <= 1'b0;
                pipe_a_q[g] <= '0;
            end else begin
                pipe_v_q[g] <= pipe_v_d[g];
                pipe_a_q[g] <= pipe_a_d[g];
            end
        end
    end

    // The tail stage lines up with the BRAM data for the same pixel.
    always_comb begin
        vram_we_d   = pipe_v_q[READ_LATENCY-1]
                      && (i_sprite_data != KEY)
                      && ({1'b0, pipe_a_q[READ_LATENCY-1]} < SCREEN_PIXELS);
        vram_addr_d = vram_addr_q;
        vram_din_d  = vram_din_q;
        if (vram_we_d) begin
            vram_addr_d = {~disp_bank_q, pipe_a_q[READ_LATENCY-1]};
            vram_din_d  = i_sprite_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        disp_bank_d   = disp_bank_q;
        frame_ready_d = 1'b0;
        overrun_d     = overrun_q;
        clear_cnt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_is_layer_drawing) begin
                    state_d   = S_DRAW;
                    clear_cnt = 1'b1;
                end
            end
            S_DRAW: begin
                if (i_screenend) overrun_d = 1'b1;
                if (!i_is_layer_drawing) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 2'd0;
                end
            end
            S_FLUSH: begin
                // A screenend here, even on the completing cycle, forfeits this swap.
                if (i_screenend) overrun_d = 1'b1;
                if (i_is_layer_drawing) begin
                    state_d = S_DRAW;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                if (i_screenend) begin
                    state_d       = S_IDLE;
                    disp_bank_d   = ~disp_bank_q;
                    frame_ready_d = 1'b1;
                end else if (i_is_layer_drawing) begin
                    state_d   = S_DRAW;
                    clear_cnt = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pix_written_d = pix_written_q;
        if (clear_cnt) begin
            pix_written_d = 16'd0;
        end else if (vram_we_q && (pix_written_q != 16'hFFFF)) begin
            pix_written_d = pix_written_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            flush_cnt_q   <= 2'd0;
            vram_we_q     <= 1'b0;
            vram_addr_q   <= '0;
            vram_din_q    <= '0;
            disp_bank_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            pix_written_q <= 16'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            vram_we_q     <= vram_we_d;
            vram_addr_q   <= vram_addr_d;
            vram_din_q    <= vram_din_d;
            disp_bank_q   <= disp_bank_d;
            frame_ready_q <= frame_ready_d;
            pix_written_q <= pix_written_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_vram_we     = vram_we_q;
    assign o_vram_addr   = vram_addr_q;
    assign o_vram_din    = vram_din_q;
    assign o_disp_bank   = disp_bank_q;
    assign o_frame_ready = frame_ready_q;
    assign o_pix_written = pix_written_q;
    assign o_overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_blit_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_blit_writer
// Brief   : Directed bench with a write scoreboard for vram_blit_writer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vram_blit_writer;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        i_is_layer_drawing = 1'b0;
    logic [15:0] i_address_screen = '0;
    logic [13:0] i_address_s = '0;
    logic        i_screenend = 1'b0;
    logic [13:0] o_sprite_addr;
    logic [11:0] i_sprite_data = '0;
    logic        o_vram_we;
    logic [16:0] o_vram_addr;
    logic [11:0] o_vram_din;
    logic        o_disp_bank;
    logic        o_frame_ready;
    logic [15:0] o_pix_written;
    logic        o_overrun;

    logic [11:0] mem [16384];
    logic [28:0] q [$];
    logic        bank_m = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          fr_cnt = 0;

    vram_blit_writer dut (
        .CLK                (CLK),
        .rst                (rst),
        .i_is_layer_drawing (i_is_layer_drawing),
        .i_address_screen   (i_address_screen),
        .i_address_s        (i_address_s),
        .i_screenend        (i_screenend),
        .o_sprite_addr      (o_sprite_addr),
        .i_sprite_data      (i_sprite_data),
        .o_vram_we          (o_vram_we),
        .o_vram_addr        (o_vram_addr),
        .o_vram_din         (o_vram_din),
        .o_disp_bank        (o_disp_bank),
        .o_frame_ready      (o_frame_ready),
        .o_pix_written      (o_pix_written),
        .o_overrun          (o_overrun)
    );

    always #5 CLK = ~CLK;

    // Sprite BRAM with one cycle of read latency.
    always @(posedge CLK) i_sprite_data <= mem[o_sprite_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (rst && o_frame_ready) fr_cnt++;
        if (rst && o_vram_we) begin
            chk("wr_expected", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) chk("wr_data", {3'd0, o_vram_addr, o_vram_din}, {3'd0, q.pop_front()});
        end
    end

    task automatic step(input logic d, input logic se, input logic [15:0] a, input logic [13:0] s);
        i_is_layer_drawing = d;
        i_screenend        = se;
        i_address_screen   = a;
        i_address_s        = s;
        if (d && mem[s] != KEY && a < 16'd57600) q.push_back({~bank_m, a, mem[s]});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 14'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},    {31'd0, o_vram_we},     32'd0);
        chk({tag, "_addr"},  {15'd0, o_vram_addr},   32'd0);
        chk({tag, "_din"},   {20'd0, o_vram_din},    32'd0);
        chk({tag, "_bank"},  {31'd0, o_disp_bank},   32'd0);
        chk({tag, "_fr"},    {31'd0, o_frame_ready}, 32'd0);
        chk({tag, "_pix"},   {16'd0, o_pix_written}, 32'd0);
        chk({tag, "_ovr"},   {31'd0, o_overrun},     32'd0);
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) begin
            logic [11:0] v;
            v = 12'(a) ^ 12'h0A5;
            mem[a] = (v == KEY) ? 12'h000 : v;
        end
        mem[10]  = 12'h123;
        mem[100] = KEY;

        // Reset state
        #23;
        chk_zero("reset");
        @(posedge CLK);
        #1;
        rst = 1'b1;
        idle(2);

        // Latency: one pixel at addr 5, data 0x123
        step(1'b1, 1'b0, 16'd5, 14'd10);
        chk("lat_t1_we", {31'd0, o_vram_we}, 32'd0);
        step(1'b0, 1'b0, 16'd0, 14'd0);
        chk("lat_t2_we",   {31'd0, o_vram_we},   32'd1);
        chk("lat_t2_addr", {15'd0, o_vram_addr}, {15'd0, 17'h10005});
        chk("lat_t2_din",  {20'd0, o_vram_din},  32'h123);
        idle(5);
        chk("lat_pix", {16'd0, o_pix_written}, 32'd1);

        // Keying and clipping; DONE -> DRAW clears the count
        step(1'b1, 1'b0, 16'd7,     14'd100);
        step(1'b1, 1'b0, 16'd57600, 14'd11);
        step(1'b1, 1'b0, 16'd57599, 14'd12);
        idle(5);
        chk("key_pix",   {16'd0, o_pix_written}, 32'd1);
        chk("key_queue", q.size(), 32'd0);

        // Full frame of opaque pixels, then screenend in DONE
        for (int i = 0; i < 60672; i++)
            step(1'b1, 1'b0, 16'(i % 57600), 14'(200 + (i % 16000)));
        idle(5);
        chk("full_pix",   {16'd0, o_pix_written}, 32'd60672);
        chk("full_ovr",   {31'd0, o_overrun},     32'd0);
        chk("full_queue", q.size(),               32'd0);
        step(1'b0, 1'b1, 16'd0, 14'd0);
        bank_m = 1'b1;
        chk("full_fr",   {31'd0, o_frame_ready}, 32'd1);
        chk("full_bank", {31'd0, o_disp_bank},   32'd1);
        idle(1);
        chk("full_fr_off", {31'd0, o_frame_ready}, 32'd0);

        // Overrun: screenend while drawing, swap deferred to DONE
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(300 + i), 14'(400 + i));
        step(1'b1, 1'b1, 16'd305, 14'd405);
        chk("ovr_flag", {31'd0, o_overrun},     32'd1);
        chk("ovr_bank", {31'd0, o_disp_bank},   32'd1);
        chk("ovr_fr",   {31'd0, o_frame_ready}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(306 + i), 14'(406 + i));
        idle(5);
        chk("ovr_pix",  {16'd0, o_pix_written}, 32'd9);
        chk("ovr_bank2", {31'd0, o_disp_bank},  32'd1);
        step(1'b0, 1'b1, 16'd0, 14'd0);
        bank_m = 1'b0;
        chk("ovr_swap_fr",   {31'd0, o_frame_ready}, 32'd1);
        chk("ovr_swap_bank", {31'd0, o_disp_bank},   32'd0);
        idle(1);

        // Gap: FLUSH re-enters DRAW, count kept, one swap
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'(1000 + i), 14'(600 + i));
        idle(1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'(2000 + i), 14'(700 + i));
        idle(5);
        chk("gap_pix",   {16'd0, o_pix_written}, 32'd20);
        chk("gap_queue", q.size(),               32'd0);
        chk("gap_nofr",  fr_cnt,                 32'd2);
        step(1'b0, 1'b1, 16'd0, 14'd0);
        bank_m = 1'b1;
        chk("gap_fr",   {31'd0, o_frame_ready}, 32'd1);
        chk("gap_bank", {31'd0, o_disp_bank},   32'd1);
        idle(2);
        chk("gap_frcnt", fr_cnt, 32'd3);

        // Asynchronous reset mid-frame discards in-flight pixels
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(50 + i), 14'(800 + i));
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        q.delete();
        bank_m = 1'b0;
        i_is_layer_drawing = 1'b0;
        @(posedge CLK);
        #1;
        rst = 1'b1;
        idle(6);
        chk("midrst_pix", {16'd0, o_pix_written}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
